// File: rtl/uart_rx_frame_parser.sv
// Recovers SOF/LEN/payload/CHK frames from a received byte stream, streams the
// payload with first/last markers and reports each frame as ok or errored.
module uart_rx_frame_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pl_first,
    output logic        pl_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
);
    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GET_LEN, PAYLOAD, GET_CHK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    pl_data_q, pl_data_d;
    logic          pl_valid_q, pl_valid_d;
    logic          pl_first_q, pl_first_d;
    logic          pl_last_q, pl_last_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [15:0]   err_count_q, err_count_d;

    logic len_bad;
    logic is_last;
    logic tmo_expire;

    assign len_bad    = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign is_last    = (idx_q == len_q - 8'd1);
    // Expiry is judged on the count the next edge would load, so the error
    // lands TIMEOUT_CYCLES+1 clocks after the last byte.
    assign tmo_expire = (state_q != IDLE) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                IDLE:    if (rx_data == SOF_BYTE) state_d = GET_LEN;
                GET_LEN: state_d = len_bad ? IDLE : PAYLOAD;
                PAYLOAD: if (is_last) state_d = GET_CHK;
                GET_CHK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (tmo_expire) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        len_d         = len_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        pl_data_d     = pl_data_q;
        pl_valid_d    = 1'b0;
        pl_first_d    = 1'b0;
        pl_last_d     = 1'b0;
        frame_ok_d    = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        tmo_d         = (state_q == IDLE || rx_valid || tmo_expire) ? '0 : tmo_q + TW'(1);

        if (rx_valid) begin
            case (state_q)
                GET_LEN: begin
                    if (len_bad) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b01;
                        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
                    end else begin
                        len_d = rx_data;
                        chk_d = rx_data;
                        idx_d = 8'd0;
                    end
                end
                PAYLOAD: begin
                    pl_valid_d = 1'b1;
                    pl_data_d  = rx_data;
                    pl_first_d = (idx_q == 8'd0);
                    pl_last_d  = is_last;
                    chk_d      = chk_q ^ rx_data;
                    idx_d      = idx_q + 8'd1;
                end
                GET_CHK: begin
                    if (rx_data == chk_q) begin
                        frame_ok_d    = 1'b1;
                        frame_count_d = (frame_count_q == 16'hFFFF) ? frame_count_q : frame_count_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b10;
                        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end else if (tmo_expire) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b11;
            err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q         <= '0;
            idx_q         <= '0;
            chk_q         <= '0;
            tmo_q         <= '0;
            pl_data_q     <= '0;
            pl_valid_q    <= 1'b0;
            pl_first_q    <= 1'b0;
            pl_last_q     <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= '0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            len_q         <= len_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            tmo_q         <= tmo_d;
            pl_data_q     <= pl_data_d;
            pl_valid_q    <= pl_valid_d;
            pl_first_q    <= pl_first_d;
            pl_last_q     <= pl_last_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign pl_data     = pl_data_q;
    assign pl_valid    = pl_valid_q;
    assign pl_first    = pl_first_q;
    assign pl_last     = pl_last_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: each scenario queues the events
// it expects (with exact cycle) and a negedge monitor consumes them.
module tb_uart_rx_frame_parser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  pl_data;
    logic        pl_valid, pl_first, pl_last, frame_ok, frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_count, err_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    uart_rx_frame_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_first(pl_first), .pl_last(pl_last),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 1 payload byte, 2 frame_ok, 3 frame_err
    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       first;
        logic       last;
        logic [1:0] code;
        int         at;
    } ev_t;
    ev_t sb[$];

    // Called at a negedge; the event is due in the cycle after the byte is sampled.
    task automatic expect_ev(int kind, logic [7:0] d, logic f, logic l, logic [1:0] code, int delay);
        ev_t e;
        e.kind = kind; e.data = d; e.first = f; e.last = l; e.code = code; e.at = cyc + delay;
        sb.push_back(e);
    endtask

    task automatic send(logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (pl_valid || frame_ok || frame_err)) begin
            ev_t e;
            int  k;
            tests_run++;
            k = pl_valid ? 1 : (frame_ok ? 2 : 3);
            if ((frame_ok && frame_err) || (pl_valid && (frame_ok || frame_err))) begin
                tests_failed++;
                $display("FAIL excl_pulses cyc=%0d pl_valid=%b frame_ok=%b frame_err=%b required at most one", cyc, pl_valid, frame_ok, frame_err);
            end else if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_event cyc=%0d kind=%0d data=%h required no event", cyc, k, pl_data);
            end else begin
                e = sb.pop_front();
                if (k !== e.kind || cyc !== e.at) begin
                    tests_failed++;
                    $display("FAIL event_kind_time got kind=%0d cyc=%0d required kind=%0d cyc=%0d", k, cyc, e.kind, e.at);
                end else if (k == 1 && {pl_data, pl_first, pl_last} !== {e.data, e.first, e.last}) begin
                    tests_failed++;
                    $display("FAIL payload got data=%h first=%b last=%b required data=%h first=%b last=%b",
                             pl_data, pl_first, pl_last, e.data, e.first, e.last);
                end else if (k == 3 && err_code !== e.code) begin
                    tests_failed++;
                    $display("FAIL err_code got %b required %b", err_code, e.code);
                end else begin
                    $display("[TB] cyc=%0d event kind=%0d data=%h code=%b ok", cyc, k, pl_data, err_code);
                end
            end
        end
    end

    task automatic drain(string name);
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
        idle(2);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain got %0d pending events required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_counts(string name, logic [15:0] fc, logic [15:0] ec);
        tests_run++;
        if (frame_count !== fc || err_count !== ec) begin
            tests_failed++;
            $display("FAIL %s_counts got frame=%0d err=%0d required frame=%0d err=%0d", name, frame_count, err_count, fc, ec);
        end else begin
            $display("[TB] %s counts frame=%0d err=%0d", name, frame_count, err_count);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({pl_data, pl_valid, pl_first, pl_last, frame_ok, frame_err, err_code, frame_count, err_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state got pl_data=%h pv=%b ok=%b err=%b code=%b fc=%0d ec=%0d required all 0",
                     pl_data, pl_valid, frame_ok, frame_err, err_code, frame_count, err_count);
        end else begin
            $display("[TB] reset state ok");
        end
    endtask

    task automatic test_good_frame();
        send(8'hA5); send(8'h03);
        expect_ev(1, 8'h11, 1, 0, 0, 1); send(8'h11); idle(1);
        expect_ev(1, 8'h22, 0, 0, 0, 1); send(8'h22); idle(1);
        expect_ev(1, 8'h33, 0, 1, 0, 1); send(8'h33); idle(1);
        expect_ev(2, 0, 0, 0, 0, 1);     send(8'h03);
        drain("good");
        check_counts("good", 16'd1, 16'd0);
    endtask

    task automatic test_garbage();
        send(8'h00); idle(1); send(8'hFF); idle(1); send(8'h5A); idle(1);
        send(8'hA5); idle(1); send(8'h01); idle(1);
        expect_ev(1, 8'h7E, 1, 1, 0, 1); send(8'h7E); idle(1);
        expect_ev(2, 0, 0, 0, 0, 1);     send(8'h7F);
        drain("garbage");
        check_counts("garbage", 16'd2, 16'd0);
    endtask

    task automatic test_bad_checksum();
        send(8'hA5); send(8'h02);
        expect_ev(1, 8'hAA, 1, 0, 0, 1); send(8'hAA);
        expect_ev(1, 8'h55, 0, 1, 0, 1); send(8'h55);
        expect_ev(3, 0, 0, 0, 2'b10, 1); send(8'h00);
        drain("badchk");
        check_counts("badchk", 16'd2, 16'd1);
        tests_run++;
        if (err_code !== 2'b10) begin
            tests_failed++;
            $display("FAIL badchk_code_held got %b required 10", err_code);
        end
    endtask

    task automatic test_bad_len();
        send(8'hA5); expect_ev(3, 0, 0, 0, 2'b01, 1); send(8'h00); idle(2);
        send(8'hA5); expect_ev(3, 0, 0, 0, 2'b01, 1); send(8'h11); idle(2);
        send(8'hA5); send(8'h01);
        expect_ev(1, 8'h42, 1, 1, 0, 1); send(8'h42);
        expect_ev(2, 0, 0, 0, 0, 1);     send(8'h43);
        drain("badlen");
        check_counts("badlen", 16'd3, 16'd3);
    endtask

    // Two frames with every byte in consecutive cycles; the second carries SOF as payload.
    task automatic test_back_to_back();
        send(8'hA5); send(8'h02);
        expect_ev(1, 8'h10, 1, 0, 0, 1); send(8'h10);
        expect_ev(1, 8'h20, 0, 1, 0, 1); send(8'h20);
        expect_ev(2, 0, 0, 0, 0, 1);     send(8'h32);
        send(8'hA5); send(8'h01);
        expect_ev(1, 8'hA5, 1, 1, 0, 1); send(8'hA5);
        expect_ev(2, 0, 0, 0, 0, 1);     send(8'hA4);
        drain("b2b");
        check_counts("b2b", 16'd5, 16'd3);
    endtask

    task automatic test_timeout();
        send(8'hA5); idle(1); send(8'h02); idle(1);
        expect_ev(1, 8'h11, 1, 0, 0, 1);
        expect_ev(3, 0, 0, 0, 2'b11, 101);
        send(8'h11);
        idle(110);
        drain("timeout");
        check_counts("timeout", 16'd5, 16'd4);
    endtask

    task automatic test_byte_at_expiry();
        send(8'hA5); idle(1); send(8'h02); idle(1);
        expect_ev(1, 8'h11, 1, 0, 0, 1); send(8'h11);
        idle(99);
        expect_ev(1, 8'h22, 0, 1, 0, 1); send(8'h22); idle(3);
        expect_ev(2, 0, 0, 0, 0, 1);     send(8'h31);
        drain("expiry");
        check_counts("expiry", 16'd6, 16'd4);
    endtask

    task automatic test_reset_mid_frame();
        send(8'hA5); send(8'h04);
        expect_ev(1, 8'h01, 1, 0, 0, 1); send(8'h01);
        expect_ev(1, 8'h02, 0, 0, 0, 1); send(8'h02);
        idle(1);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({pl_valid, frame_ok, frame_err, err_code, frame_count, err_count, pl_data} !== '0) begin
                tests_failed++;
                $display("FAIL rst_mid_outputs got pv=%b ok=%b err=%b code=%b fc=%0d ec=%0d required all 0",
                         pl_valid, frame_ok, frame_err, err_code, frame_count, err_count);
            end
        end
        rst_n = 1'b1;
        idle(2);
        send(8'hA5); send(8'h01);
        expect_ev(1, 8'h55, 1, 1, 0, 1); send(8'h55);
        expect_ev(2, 0, 0, 0, 0, 1);     send(8'h54);
        drain("rstmid");
        check_counts("rstmid", 16'd1, 16'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        idle(2);
        test_good_frame();
        test_garbage();
        test_bad_checksum();
        test_bad_len();
        test_back_to_back();
        test_timeout();
        test_byte_at_expiry();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got simulation still running required finish");
        $fatal(1, "bench timed out");
    end
endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Downstream consumer of the UART receiver. Takes the byte stream (`rx_data`/`rx_valid`) and recovers framed packets of the form SOF, LEN, payload, CHK. It forwards payload bytes to the application with first/last markers and reports each frame's outcome as ok or error. It keeps saturating good/bad frame counters and aborts frames that stall via an inter-byte timeout.

## Interface
- `SOF_BYTE`, 8'hA5: start-of-frame marker.
- `MAX_LEN`, 16: largest legal LEN value (1..255).
- `TIMEOUT_CYCLES`, 50000: max clk cycles allowed between bytes inside a frame (≈11.5 byte-times at 50 MHz/115200).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte, valid when `rx_valid`=1.
- `rx_valid`  in  1  one-clk pulse per received byte.
- `pl_data`  out  8  payload byte.
- `pl_valid`  out  1  one-clk pulse per payload byte.
- `pl_first`  out  1  high with `pl_valid` on payload byte 0.
- `pl_last`  out  1  high with `pl_valid` on final payload byte.
- `frame_ok`  out  1  one-clk pulse: checksum matched.
- `frame_err`  out  1  one-clk pulse: frame aborted.
- `err_code`  out  2  cause of last error, held until next error: 01 bad LEN, 10 checksum mismatch, 11 timeout.
- `frame_count`  out  16  good frames, saturating at 16'hFFFF.
- `err_count`  out  16  errored frames, saturating at 16'hFFFF.

## Operation
- The frame is SOF, LEN, then LEN payload bytes, then CHK.
- CHK is the XOR of LEN and all payload bytes.
- States are IDLE, GET_LEN, PAYLOAD, GET_CHK.
- IDLE:
  - byte == `SOF_BYTE` -> GET_LEN.
  - Any other byte is silently dropped (no error, no count).
- GET_LEN:
  - LEN==0 or LEN>`MAX_LEN` -> `frame_err`, code 01, `err_count`++, go to IDLE.
  - The rejected LEN byte is not re-examined as SOF.
  - Otherwise latch LEN, seed the running XOR with LEN, clear the byte index, go to PAYLOAD.
- PAYLOAD:
  - Each byte: emit it on `pl_data`/`pl_valid`, XOR it into the running value, increment the index.
  - `pl_first` is high when index==0.
  - `pl_last` is high when index==LEN-1; that byte moves the state to GET_CHK.
- GET_CHK:
  - Byte == running XOR -> `frame_ok`, `frame_count`++.
  - Otherwise `frame_err`, code 10, `err_count`++.
  - Either way -> IDLE.
- Payload is streamed before the checksum is known. The consumer discards the frame on `frame_err`.
- Timeout counter:
  - Cleared on every `rx_valid`; held at 0 in IDLE.
  - Increments each cycle in any other state.
  - On reaching `TIMEOUT_CYCLES`: `frame_err`, code 11, `err_count`++, go to IDLE, counter cleared.
- SOF bytes seen inside LEN/PAYLOAD/CHK are treated as data; there is no resync mid-frame.
- Counters saturate and never wrap.

## Timing
- All outputs are registered. `pl_*`, `frame_ok` and `frame_err` assert exactly 1 clk after the `rx_valid` cycle of the causing byte, for 1 clk.
- Timeout `frame_err` asserts 1 clk after the counter reaches `TIMEOUT_CYCLES`, i.e. `TIMEOUT_CYCLES`+1 clks after the last `rx_valid`.
- Simultaneous `rx_valid` and timeout expiry in the same cycle: the byte wins. The counter clears, the byte is processed, and no error is raised.
- `frame_ok` and `frame_err` are never high in the same cycle.
- `pl_valid` never coincides with `frame_ok` or `frame_err`.
- Back-to-back frames are supported: a SOF in the cycle after GET_CHK completes is accepted with zero gap.
- `rx_valid` pulses are at least one byte-time apart. Consecutive-cycle pulses must still each be processed.
- Reset (async, any state): state=IDLE and all outputs are 0, including `err_code`=00, counters=0, and timeout counter=0. A partial frame is discarded with no `frame_err`.

## Test plan
- Good frame A5 03 11 22 33 03:
  - `pl_valid` pulses with 11, 22, 33.
  - `pl_first` on 11, `pl_last` on 33.
  - `frame_ok` 1 clk after the CHK byte; `frame_count`=1, `err_count`=0.
- Garbage then frame 00 FF 5A A5 01 7E 7F:
  - The leading bytes are ignored.
  - One payload byte 7E with `pl_first`=`pl_last`=1, then `frame_ok`.
- Bad checksum A5 02 AA 55 00 (correct CHK is FD):
  - Payload AA, 55 is emitted.
  - `frame_err` with `err_code`=10; `err_count`=1, `frame_count` unchanged.
- Bad length:
  - A5 00 -> `frame_err`, code 01.
  - A5 11 (with `MAX_LEN`=16) -> `frame_err`, code 01.
  - A following A5 01 42 43 -> `frame_ok`.
- Timeout with `TIMEOUT_CYCLES`=100:
  - Send A5 02 11, then idle -> `frame_err`, code 11, exactly 101 clks after the 11 byte.
  - In a separate run, drive a byte exactly at expiry -> no error.
- Reset mid-frame: A5 04 01 02, assert `rst_n`=0 for 3 clks, then A5 01 55 54 -> all outputs 0 during reset, then `frame_ok`, `frame_count`=1, `err_count`=0.
